// File: rtl/conv_layer_sequencer.sv
// Per-layer sequencer: accepts a layer descriptor, configures weight_rotator, gates one weight load,
// gates one layer of image beats, then waits for the final t_last. Optional drain watchdog: LAYER_SEQ_TIMEOUT_EN.
module conv_layer_sequencer #(
   parameter int CONV_UNITS             = 8,
   parameter int ADDRS_WIDTH            = 10,
   parameter int ROTATE_WIDTH           = 20,
   parameter int CH_IN_COUNTER_WIDTH    = 10,
   parameter int IM_WIDTH_COUNTER_WIDTH = 9,
   parameter int NUM_BLKS_COUNTER_WIDTH = 8
`ifdef LAYER_SEQ_TIMEOUT_EN
   ,parameter int TIMEOUT_CYCLES        = 1048576
`endif
) (
   input  logic                              clk,
   input  logic                              rstn,
   input  logic                              cfg_valid,
   output logic                              cfg_rdy,
   input  logic [CH_IN_COUNTER_WIDTH-1:0]    cfg_ch_in,
   input  logic [IM_WIDTH_COUNTER_WIDTH:0]   cfg_im_width,
   input  logic [15:0]                       cfg_im_height,
   input  logic                              cfg_conv_mode,
   input  logic                              cfg_max_mode,
   output logic [ADDRS_WIDTH-1:0]            wr_write_depth,
   output logic [ROTATE_WIDTH-1:0]           wr_rotate_amount,
   output logic [CH_IN_COUNTER_WIDTH-1:0]    wr_im_channels,
   output logic [IM_WIDTH_COUNTER_WIDTH-1:0] wr_im_width,
   output logic [NUM_BLKS_COUNTER_WIDTH-1:0] wr_im_blocks,
   output logic                              wr_conv_mode,
   output logic                              wr_max_mode,
   input  logic                              w_s_valid,
   output logic                              w_s_rdy,
   output logic                              wr_l_valid,
   input  logic                              wr_l_rdy,
   output logic                              x_en,
   input  logic                              x_beat,
   input  logic                              t_last,
   output logic                              busy,
   output logic                              done,
   output logic                              err
);

   localparam int LOG2_CU = $clog2(CONV_UNITS);
   localparam int CH_W    = CH_IN_COUNTER_WIDTH;
   localparam int IMW     = IM_WIDTH_COUNTER_WIDTH;
   localparam int NB_W    = NUM_BLKS_COUNTER_WIDTH;
   localparam int KCH_W   = CH_W + 2;
   localparam int WCNT_W  = ADDRS_WIDTH + 1;
   localparam int ROT_FW  = IMW + 1 + 16;

   typedef enum logic [2:0] {S_IDLE, S_CALC, S_LOAD_W, S_RUN, S_DRAIN} state_t;

   state_t              state_q, state_d;
   logic [CH_W-1:0]     ch_in_q, ch_in_d;
   logic [IMW:0]        im_width_q, im_width_d;
   logic [15:0]         im_height_q, im_height_d;
   logic                conv_mode_q, conv_mode_d;
   logic                max_mode_q, max_mode_d;
   logic [ADDRS_WIDTH-1:0]  wr_write_depth_q, wr_write_depth_d;
   logic [ROTATE_WIDTH-1:0] wr_rotate_amount_q, wr_rotate_amount_d;
   logic [CH_W-1:0]     wr_im_channels_q, wr_im_channels_d;
   logic [IMW-1:0]      wr_im_width_q, wr_im_width_d;
   logic [NB_W-1:0]     wr_im_blocks_q, wr_im_blocks_d;
   logic                wr_conv_mode_q, wr_conv_mode_d;
   logic                wr_max_mode_q, wr_max_mode_d;
   logic [WCNT_W-1:0]   w_target_q, w_target_d;
   logic [WCNT_W-1:0]   w_cnt_q, w_cnt_d;
   logic [31:0]         x_target_q, x_target_d;
   logic [31:0]         x_cnt_q, x_cnt_d;
   logic                x_en_q, x_en_d;
   logic                tlast_pend_q, tlast_pend_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic                cfg_rdy_q, cfg_rdy_d;
`ifdef LAYER_SEQ_TIMEOUT_EN
   logic [31:0]         wd_cnt_q, wd_cnt_d;
   logic [31:0]         wd_inc;
`endif

   logic [1:0]          k_val;
   logic [15:0]         nb, eb;
   logic [KCH_W-1:0]    kch, depth_full;
   logic [ADDRS_WIDTH-1:0] depth_calc;
   logic                reject;
   logic [WCNT_W-1:0]   w_inc;
   logic [31:0]         x_inc;

   // Layer geometry derived from the latched descriptor; consumed only in CALC.
   always_comb begin
      k_val      = conv_mode_q ? 2'd1 : 2'd3;
      nb         = im_height_q >> LOG2_CU;
      eb         = max_mode_q ? (nb >> 1) : nb;
      kch        = KCH_W'(ch_in_q) * KCH_W'(k_val);
      depth_full = max_mode_q ? (kch >> 1) : kch;
      depth_calc = ADDRS_WIDTH'(depth_full);
      reject     = ((im_height_q & 16'(CONV_UNITS - 1)) != 16'd0) || (nb == 16'd0) ||
                   (max_mode_q && (nb[0] || kch[0]));
      w_inc      = (&w_cnt_q) ? w_cnt_q : w_cnt_q + WCNT_W'(1);
      x_inc      = (&x_cnt_q) ? x_cnt_q : x_cnt_q + 32'd1;
   end

   always_comb begin
      state_d            = state_q;
      ch_in_d            = ch_in_q;
      im_width_d         = im_width_q;
      im_height_d        = im_height_q;
      conv_mode_d        = conv_mode_q;
      max_mode_d         = max_mode_q;
      wr_write_depth_d   = wr_write_depth_q;
      wr_rotate_amount_d = wr_rotate_amount_q;
      wr_im_channels_d   = wr_im_channels_q;
      wr_im_width_d      = wr_im_width_q;
      wr_im_blocks_d     = wr_im_blocks_q;
      wr_conv_mode_d     = wr_conv_mode_q;
      wr_max_mode_d      = wr_max_mode_q;
      w_target_d         = w_target_q;
      w_cnt_d            = w_cnt_q;
      x_target_d         = x_target_q;
      x_cnt_d            = x_cnt_q;
      x_en_d             = x_en_q;
      tlast_pend_d       = tlast_pend_q;
      done_d             = 1'b0;
      err_d              = 1'b0;
`ifdef LAYER_SEQ_TIMEOUT_EN
      wd_cnt_d           = wd_cnt_q;
      wd_inc             = (&wd_cnt_q) ? wd_cnt_q : wd_cnt_q + 32'd1;
`endif
      case (state_q)
         S_IDLE: begin
            if (cfg_valid && cfg_rdy_q) begin
               ch_in_d     = cfg_ch_in;
               im_width_d  = cfg_im_width;
               im_height_d = cfg_im_height;
               conv_mode_d = cfg_conv_mode;
               max_mode_d  = cfg_max_mode;
               state_d     = S_CALC;
            end
         end
         S_CALC: begin
            if (reject) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               wr_write_depth_d   = depth_calc;
               wr_rotate_amount_d = ROTATE_WIDTH'(ROT_FW'(im_width_q) * ROT_FW'(eb) - ROT_FW'(1));
               wr_im_channels_d   = CH_W'(ch_in_q - 1'b1);
               wr_im_width_d      = IMW'(im_width_q - 1'b1);
               wr_im_blocks_d     = NB_W'(eb - 16'd1);
               wr_conv_mode_d     = conv_mode_q;
               wr_max_mode_d      = max_mode_q;
               w_target_d         = WCNT_W'(depth_calc) + WCNT_W'(1);
               x_target_d         = 32'(64'(ch_in_q) * 64'(im_width_q) * 64'(eb));
               w_cnt_d            = '0;
               x_cnt_d            = '0;
               tlast_pend_d       = 1'b0;
               state_d            = S_LOAD_W;
            end
         end
         S_LOAD_W: begin
            if (w_s_valid && wr_l_rdy) begin
               w_cnt_d = w_inc;
               if (w_inc >= w_target_q) begin
                  x_en_d  = 1'b1;
                  state_d = S_RUN;
               end
            end
         end
         S_RUN: begin
            if (x_beat && x_en_q) begin
               x_cnt_d = x_inc;
               if (x_inc >= x_target_q) begin
                  // A t_last coinciding with the final image beat must not be lost.
                  x_en_d       = 1'b0;
                  tlast_pend_d = t_last;
                  state_d      = S_DRAIN;
`ifdef LAYER_SEQ_TIMEOUT_EN
                  wd_cnt_d     = '0;
`endif
               end
            end
         end
         S_DRAIN: begin
            if (t_last || tlast_pend_q) begin
               done_d       = 1'b1;
               tlast_pend_d = 1'b0;
               state_d      = S_IDLE;
            end
`ifdef LAYER_SEQ_TIMEOUT_EN
            else begin
               wd_cnt_d = wd_inc;
               if (wd_inc >= 32'(TIMEOUT_CYCLES)) begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end
            end
`endif
         end
         default: state_d = S_IDLE;
      endcase
      cfg_rdy_d = (state_d == S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q            <= S_IDLE;
         ch_in_q            <= '0;
         im_width_q         <= '0;
         im_height_q        <= '0;
         conv_mode_q        <= 1'b0;
         max_mode_q         <= 1'b0;
         wr_write_depth_q   <= '0;
         wr_rotate_amount_q <= '0;
         wr_im_channels_q   <= '0;
         wr_im_width_q      <= '0;
         wr_im_blocks_q     <= '0;
         wr_conv_mode_q     <= 1'b0;
         wr_max_mode_q      <= 1'b0;
         w_target_q         <= '0;
         w_cnt_q            <= '0;
         x_target_q         <= '0;
         x_cnt_q            <= '0;
         x_en_q             <= 1'b0;
         tlast_pend_q       <= 1'b0;
         done_q             <= 1'b0;
         err_q              <= 1'b0;
         cfg_rdy_q          <= 1'b0;
`ifdef LAYER_SEQ_TIMEOUT_EN
         wd_cnt_q           <= '0;
`endif
      end else begin
         state_q            <= state_d;
         ch_in_q            <= ch_in_d;
         im_width_q         <= im_width_d;
         im_height_q        <= im_height_d;
         conv_mode_q        <= conv_mode_d;
         max_mode_q         <= max_mode_d;
         wr_write_depth_q   <= wr_write_depth_d;
         wr_rotate_amount_q <= wr_rotate_amount_d;
         wr_im_channels_q   <= wr_im_channels_d;
         wr_im_width_q      <= wr_im_width_d;
         wr_im_blocks_q     <= wr_im_blocks_d;
         wr_conv_mode_q     <= wr_conv_mode_d;
         wr_max_mode_q      <= wr_max_mode_d;
         w_target_q         <= w_target_d;
         w_cnt_q            <= w_cnt_d;
         x_target_q         <= x_target_d;
         x_cnt_q            <= x_cnt_d;
         x_en_q             <= x_en_d;
         tlast_pend_q       <= tlast_pend_d;
         done_q             <= done_d;
         err_q              <= err_d;
         cfg_rdy_q          <= cfg_rdy_d;
`ifdef LAYER_SEQ_TIMEOUT_EN
         wd_cnt_q           <= wd_cnt_d;
`endif
      end
   end

   // Weight handshake passes straight through, but only while loading.
   assign wr_l_valid       = (state_q == S_LOAD_W) && w_s_valid;
   assign w_s_rdy          = (state_q == S_LOAD_W) && wr_l_rdy;
   assign cfg_rdy          = cfg_rdy_q;
   assign busy             = (state_q != S_IDLE);
   assign x_en             = x_en_q;
   assign done             = done_q;
   assign err              = err_q;
   assign wr_write_depth   = wr_write_depth_q;
   assign wr_rotate_amount = wr_rotate_amount_q;
   assign wr_im_channels   = wr_im_channels_q;
   assign wr_im_width      = wr_im_width_q;
   assign wr_im_blocks     = wr_im_blocks_q;
   assign wr_conv_mode     = wr_conv_mode_q;
   assign wr_max_mode      = wr_max_mode_q;

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Scoreboard bench for conv_layer_sequencer: drivers push expected layer outcomes, a monitor checks them on done/err.
module tb_conv_layer_sequencer;

   logic        clk, rstn, cfg_valid, cfg_conv_mode, cfg_max_mode;
   logic        cfg_rdy;
   logic [9:0]  cfg_ch_in, cfg_im_width;
   logic [15:0] cfg_im_height;
   logic [9:0]  wr_write_depth;
   logic [19:0] wr_rotate_amount;
   logic [9:0]  wr_im_channels;
   logic [8:0]  wr_im_width;
   logic [7:0]  wr_im_blocks;
   logic        wr_conv_mode, wr_max_mode;
   logic        w_s_valid, w_s_rdy, wr_l_valid, wr_l_rdy;
   logic        x_en, x_beat, t_last, busy, done, err;

   conv_layer_sequencer dut (
      .clk(clk), .rstn(rstn), .cfg_valid(cfg_valid), .cfg_rdy(cfg_rdy),
      .cfg_ch_in(cfg_ch_in), .cfg_im_width(cfg_im_width), .cfg_im_height(cfg_im_height),
      .cfg_conv_mode(cfg_conv_mode), .cfg_max_mode(cfg_max_mode),
      .wr_write_depth(wr_write_depth), .wr_rotate_amount(wr_rotate_amount),
      .wr_im_channels(wr_im_channels), .wr_im_width(wr_im_width), .wr_im_blocks(wr_im_blocks),
      .wr_conv_mode(wr_conv_mode), .wr_max_mode(wr_max_mode),
      .w_s_valid(w_s_valid), .w_s_rdy(w_s_rdy), .wr_l_valid(wr_l_valid), .wr_l_rdy(wr_l_rdy),
      .x_en(x_en), .x_beat(x_beat), .t_last(t_last), .busy(busy), .done(done), .err(err)
   );

   typedef struct {
      bit is_err;
      int depth, rot, ch, wid, blk, cm, mm, wb, xb, lat;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic void chk(string nm, longint act, longint expv);
      n_cmp++;
      if (act != expv) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero(string tag);
      chk({tag, "_cfg_rdy"}, cfg_rdy, 0);
      chk({tag, "_w_s_rdy"}, w_s_rdy, 0);
      chk({tag, "_wr_l_valid"}, wr_l_valid, 0);
      chk({tag, "_x_en"}, x_en, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_err"}, err, 0);
      chk({tag, "_wr_cfg"}, {wr_write_depth, wr_rotate_amount, wr_im_channels, wr_im_width,
                             wr_im_blocks, wr_conv_mode, wr_max_mode}, 0);
   endtask

   // Monitor: counts handshakes between layer events and checks each done/err against the scoreboard.
   initial begin
      int wc, wlc, xc, since;
      exp_t e;
      wc = 0; wlc = 0; xc = 0; since = 1000;
      forever begin
         @(negedge clk);
         if (!rstn) begin
            wc = 0; wlc = 0; xc = 0; since = 1000;
         end else begin
            if (w_s_valid && w_s_rdy) wc++;
            if (wr_l_valid && wr_l_rdy) wlc++;
            if (x_beat && x_en) xc++;
            since++;
            if (done || err) begin
               chk("event_expected", sb.size() > 0, 1);
               if (sb.size() > 0) begin
                  e = sb.pop_front();
                  chk("err_flag", err, e.is_err);
                  chk("done_flag", done, !e.is_err);
                  chk("wr_write_depth", wr_write_depth, e.depth);
                  chk("wr_rotate_amount", wr_rotate_amount, e.rot);
                  chk("wr_im_channels", wr_im_channels, e.ch);
                  chk("wr_im_width", wr_im_width, e.wid);
                  chk("wr_im_blocks", wr_im_blocks, e.blk);
                  chk("wr_conv_mode", wr_conv_mode, e.cm);
                  chk("wr_max_mode", wr_max_mode, e.mm);
                  chk("w_beats_upstream", wc, e.wb);
                  chk("w_beats_rotator", wlc, e.wb);
                  chk("x_beats", xc, e.xb);
                  if (!e.is_err) chk("done_latency", since, e.lat);
               end
               wc = 0; wlc = 0; xc = 0;
            end
            if (t_last) since = 0;
         end
      end
   end

   task automatic send_cfg(input int ch, input int w, input int h, input bit cm, input bit mm);
      int n = 0;
      while (!cfg_rdy && n < 200) begin
         tick();
         n++;
      end
      if (n >= 200) chk("cfg_rdy_wait", cfg_rdy, 1);
      cfg_valid = 1'b1;
      cfg_ch_in = 10'(ch); cfg_im_width = 10'(w); cfg_im_height = 16'(h);
      cfg_conv_mode = cm; cfg_max_mode = mm;
      tick();
      cfg_valid = 1'b0;
      chk("busy_after_accept", busy, 1);
   endtask

   task automatic load_w(input bit stall);
      int n = 0;
      while (!x_en && n < 2000) begin
         w_s_valid = stall ? 1'($urandom % 2) : 1'b1;
         wr_l_rdy  = stall ? ($urandom % 3 != 0) : 1'b1;
         tick();
         n++;
      end
      if (n >= 2000) chk("load_w_timeout", x_en, 1);
      w_s_valid = 1'b0;
      wr_l_rdy  = 1'b0;
   endtask

   task automatic run_x(input int target, input bit stall, input bit coincide, input bit spur);
      int cnt = 0;
      int n = 0;
      bit b;
      while (x_en && n < 60000) begin
         b      = stall ? ($urandom % 4 != 0) : 1'b1;
         x_beat = b;
         t_last = b && ((coincide && cnt == target - 1) || (spur && cnt == 1));
         if (b) cnt++;
         tick();
         n++;
      end
      chk("x_beats_driven", cnt, target);
      t_last = 1'b0;
      x_beat = 1'b1;
      tick();
      x_beat = 1'b0;
   endtask

   task automatic drain(input bit coincide);
      int n = 0;
      if (!coincide) begin
         repeat (3) tick();
         t_last = 1'b1;
         tick();
         t_last = 1'b0;
      end
      while (!cfg_rdy && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) chk("drain_timeout", cfg_rdy, 1);
   endtask

   task automatic run_layer(input int ch, input int w, input int h, input bit cm, input bit mm,
                            input bit stall, input bit coincide, input bit spur, input exp_t e);
      sb.push_back(e);
      send_cfg(ch, w, h, cm, mm);
      load_w(stall);
      run_x(e.xb, stall, coincide, spur);
      drain(coincide);
   endtask

   task automatic reject_layer(input int ch, input int w, input int h, input bit cm, input bit mm,
                               input exp_t e);
      sb.push_back(e);
      send_cfg(ch, w, h, cm, mm);
      tick();
      chk("reject_err_pulse", err, 1);
      chk("reject_no_w_rdy", w_s_rdy, 0);
      tick();
      chk("reject_cfg_rdy", cfg_rdy, 1);
      chk("reject_err_one_cycle", err, 0);
   endtask

   initial begin
      int n;
      exp_t held;
      rstn = 1'b0; cfg_valid = 1'b0; cfg_ch_in = '0; cfg_im_width = '0; cfg_im_height = '0;
      cfg_conv_mode = 1'b0; cfg_max_mode = 1'b0; w_s_valid = 1'b0; wr_l_rdy = 1'b0;
      x_beat = 1'b0; t_last = 1'b0;
      repeat (3) tick();
      check_zero("reset");
      rstn = 1'b1;
      tick();
      chk("post_reset_cfg_rdy", cfg_rdy, 1);
      chk("post_reset_busy", busy, 0);

      // 3x3 max-pool layer: 7 weights, 4*384*16 image beats
      held = '{0, 6, 6143, 3, 383, 15, 0, 1, 7, 24576, 1};
      run_layer(4, 384, 256, 0, 1, 0, 0, 0, held);

      // Rejected descriptors keep the previous configuration
      held.is_err = 1; held.wb = 0; held.xb = 0; held.lat = 0;
      reject_layer(4, 384, 250, 0, 1, held);
      reject_layer(4, 384, 24, 0, 1, held);
      reject_layer(1, 384, 16, 0, 1, held);

      // 3x3 no pool: check configuration, then reset mid-RUN
      send_cfg(4, 384, 256, 0, 0);
      tick();
      chk("B_depth", wr_write_depth, 12);
      chk("B_rotate", wr_rotate_amount, 12287);
      chk("B_blocks", wr_im_blocks, 31);
      chk("B_channels", wr_im_channels, 3);
      chk("B_width", wr_im_width, 383);
      load_w(0);
      chk("B_x_en", x_en, 1);
      x_beat = 1'b1;
      repeat (100) tick();
      rstn = 1'b0;
      x_beat = 1'b0;
      tick();
      check_zero("midrun_reset");
      rstn = 1'b1;
      tick();
      chk("midrun_reset_cfg_rdy", cfg_rdy, 1);

      // 1x1 no pool: configuration only
      send_cfg(4, 384, 256, 1, 0);
      tick();
      chk("C_depth", wr_write_depth, 4);
      chk("C_rotate", wr_rotate_amount, 12287);
      chk("C_conv_mode", wr_conv_mode, 1);
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      tick();

      // Small layers with random stalls, spurious and coincident t_last
      run_layer(1, 4, 16, 0, 0, 1, 0, 1, '{0, 3, 7, 0, 3, 1, 0, 0, 4, 8, 1});
      run_layer(2, 3, 16, 1, 1, 1, 1, 0, '{0, 1, 2, 1, 2, 0, 1, 1, 2, 6, 2});
      run_layer(2, 5, 32, 0, 1, 1, 1, 0, '{0, 3, 9, 1, 4, 1, 0, 1, 4, 20, 2});
      run_layer(3, 7, 24, 0, 0, 1, 0, 0, '{0, 9, 20, 2, 6, 2, 0, 0, 10, 63, 1});

      n = 0;
      while (sb.size() > 0 && n < 100) begin
         tick();
         n++;
      end
      chk("scoreboard_drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
